// File: rtl/div_pkg.sv
// Shared definitions for the signed restoring divider sequencer.
package div_pkg;

    // Operand / quotient width; the divider state register is twice this.
    localparam int DIV_WIDTH = 32;

    // One quotient bit per iteration, so the count always equals the width.
    localparam int DIV_ITER = 32;

    // Iteration counter width (counts 0 .. DIV_ITER-1).
    localparam int CNT_W = 5;

    // Sequencer states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_t;

    // Trial subtraction of the divisor from the partial remainder.
    // The extra top bit of the result is the borrow: set when rem < div.
    function automatic logic [DIV_WIDTH:0] trial_sub(
        input logic [DIV_WIDTH-1:0] rem,
        input logic [DIV_WIDTH-1:0] div
    );
        return {1'b0, rem} - {1'b0, div};
    endfunction

endpackage

// File: rtl/div_abs32.sv
// Conditional two's-complement negate. Used both to take magnitudes of the
// signed operands and to restore the sign of the quotient and remainder.
// 0x80000000 negates to itself, which reads correctly as an unsigned 2^31.
module div_abs32
    import div_pkg::*;
(
    input  logic [DIV_WIDTH-1:0] value,
    input  logic                 negate,
    output logic [DIV_WIDTH-1:0] result
);

    // Negate when asked, pass through otherwise.
    always_comb begin
        result = negate ? (~value + 1'b1) : value;
    end

endmodule

// File: rtl/div_ctrl.sv
// Sequencer for a signed restoring divider that sits in front of the
// multdiv unit's 64-bit divider register. The register itself lives in the
// parent; this block only produces its write data / enable and interprets
// its contents ({remainder, quotient}) as the result.
//
// Handshake: ctrl_DIV is a one-cycle start strobe with no back-pressure; it
// is accepted in every state (a start while busy aborts and restarts).
// data_resultRDY is a one-cycle valid strobe with no ready; the consumer
// must take data_result / data_remainder / data_exception in that cycle or
// later, as they hold until the next start or reset.
module div_ctrl
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH,
    parameter int ITER  = DIV_ITER
)
(
    input  logic                 clk,
    input  logic                 ctrl_reset,
    input  logic                 ctrl_DIV,
    input  logic [WIDTH-1:0]     data_operandA,
    input  logic [WIDTH-1:0]     data_operandB,
    input  logic [2*WIDTH-1:0]   data_readReg,
    output logic [2*WIDTH-1:0]   data_writeReg,
    output logic                 write_to,
    output logic [WIDTH-1:0]     data_result,
    output logic [WIDTH-1:0]     data_remainder,
    output logic                 data_exception,
    output logic                 data_resultRDY,
    output logic [1:0]           debug_state
);

    // Count value on the final iteration cycle.
    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(ITER - 1);

    // Sequencer state.
    div_state_t         state;
    logic [CNT_W-1:0]   count;
    logic               sign_a;
    logic               sign_b;
    logic [WIDTH-1:0]   abs_b;
    logic               exception;
    logic               rdy;

    // Operand magnitudes for the start cycle.
    logic [WIDTH-1:0]   abs_a_in;
    logic [WIDTH-1:0]   abs_b_in;

    // Iteration datapath.
    logic [2*WIDTH-1:0] shifted;
    logic [WIDTH:0]     trial;
    logic               borrow;
    logic [2*WIDTH-1:0] iter_word;

    // Sign-corrected results.
    logic [WIDTH-1:0]   quo_signed;
    logic [WIDTH-1:0]   rem_signed;

    // Magnitude of the dividend; written into the low half on the start edge.
    div_abs32 u_abs_a (
        .value  (data_operandA),
        .negate (data_operandA[WIDTH-1]),
        .result (abs_a_in)
    );

    // Magnitude of the divisor; latched for the whole run.
    div_abs32 u_abs_b (
        .value  (data_operandB),
        .negate (data_operandB[WIDTH-1]),
        .result (abs_b_in)
    );

    // Quotient is negative when exactly one operand was negative.
    div_abs32 u_fix_quo (
        .value  (data_readReg[WIDTH-1:0]),
        .negate (sign_a ^ sign_b),
        .result (quo_signed)
    );

    // Remainder takes the sign of the dividend (truncating division).
    div_abs32 u_fix_rem (
        .value  (data_readReg[2*WIDTH-1:WIDTH]),
        .negate (sign_a),
        .result (rem_signed)
    );

    // One restoring step: shift left, try to subtract, keep it if no borrow.
    // The remainder half is always below |B| <= 2^31, so no bit is lost
    // off the top of the shift.
    always_comb begin
        shifted = data_readReg << 1;
        trial   = trial_sub(shifted[2*WIDTH-1:WIDTH], abs_b);
        borrow  = trial[WIDTH];
        if (borrow) begin
            iter_word = shifted;
        end else begin
            iter_word = {trial[WIDTH-1:0], shifted[WIDTH-1:1], 1'b1};
        end
    end

    // Register write port: init word on start, one step per RUN cycle.
    // A start takes priority over an iteration so it can abort a run.
    always_comb begin
        write_to      = 1'b0;
        data_writeReg = '0;
        if (ctrl_reset) begin
            if (ctrl_DIV) begin
                write_to      = 1'b1;
                data_writeReg = {{WIDTH{1'b0}}, abs_a_in};
            end else if (state == RUN) begin
                write_to      = 1'b1;
                data_writeReg = iter_word;
            end
        end
    end

    // Sequencer: start/abort handling, iteration count, done strobe.
    always_ff @(posedge clk) begin
        if (!ctrl_reset) begin
            state     <= IDLE;
            count     <= '0;
            sign_a    <= 1'b0;
            sign_b    <= 1'b0;
            abs_b     <= '0;
            exception <= 1'b0;
            rdy       <= 1'b0;
        end else if (ctrl_DIV) begin
            sign_a <= data_operandA[WIDTH-1];
            sign_b <= data_operandB[WIDTH-1];
            abs_b  <= abs_b_in;
            count  <= '0;
            if (data_operandB == '0) begin
                // Nothing to iterate; report straight away.
                exception <= 1'b1;
                state     <= DONE;
                rdy       <= 1'b1;
            end else begin
                exception <= 1'b0;
                state     <= RUN;
                rdy       <= 1'b0;
            end
        end else begin
            case (state)
                IDLE: begin
                    rdy <= 1'b0;
                end
                RUN: begin
                    count <= count + 1'b1;
                    if (count == LAST_COUNT) begin
                        state <= DONE;
                        rdy   <= 1'b1;
                    end else begin
                        rdy   <= 1'b0;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    rdy   <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    rdy   <= 1'b0;
                end
            endcase
        end
    end

    // Result presentation; a divide-by-zero reports zeros.
    always_comb begin
        data_result    = exception ? '0 : quo_signed;
        data_remainder = exception ? '0 : rem_signed;
        data_exception = exception;
        data_resultRDY = rdy;
        debug_state    = state;
    end

endmodule

// File: tb/tb_div_ctrl.sv
// Bench for div_ctrl: models the external 64-bit divider register, drives
// directed and random divides, and compares against plain signed arithmetic.
module tb_div_ctrl;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        ctrl_reset;
    logic        ctrl_DIV;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic [63:0] reg_q;
    logic [63:0] data_writeReg;
    logic        write_to;
    logic [31:0] data_result;
    logic [31:0] data_remainder;
    logic        data_exception;
    logic        data_resultRDY;
    logic [1:0]  debug_state;

    always #5 clk = ~clk;

    // External divider register; its clear follows ~ctrl_reset.
    always @(posedge clk) begin
        if (!ctrl_reset) reg_q <= '0;
        else if (write_to) reg_q <= data_writeReg;
    end

    div_ctrl dut (
        .clk            (clk),
        .ctrl_reset     (ctrl_reset),
        .ctrl_DIV       (ctrl_DIV),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .data_readReg   (reg_q),
        .data_writeReg  (data_writeReg),
        .write_to       (write_to),
        .data_result    (data_result),
        .data_remainder (data_remainder),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .debug_state    (debug_state)
    );

    // ---------------- scoreboard ----------------
    int n_vec = 0;
    int n_err = 0;
    logic [64:0] exp_q[$];   // {exception, remainder, quotient}

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: truncating signed division done in 64-bit arithmetic so the
    // INT_MIN / -1 case wraps instead of overflowing.
    function automatic logic [64:0] model(input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        if (b == 32'd0) return {1'b1, 64'd0};
        sa = longint'(signed'(a));
        sb = longint'(signed'(b));
        q  = sa / sb;
        r  = sa % sb;
        return {1'b0, r[31:0], q[31:0]};
    endfunction

    // ---------------- driver tasks ----------------
    // All tasks start and end 1ns after a rising edge.
    task automatic start_only(input logic [31:0] a, input logic [31:0] b);
        ctrl_DIV      = 1'b1;
        data_operandA = a;
        data_operandB = b;
        @(posedge clk); #1;
        ctrl_DIV      = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
    endtask

    task automatic run_div(input logic [31:0] a, input logic [31:0] b, input string tag);
        int          lat;
        int          wr_cnt;
        int          exp_lat;
        logic [64:0] exp;
        exp_q.push_back(model(a, b));
        exp_lat = (b == 32'd0) ? 1 : 33;
        ctrl_DIV      = 1'b1;
        data_operandA = a;
        data_operandB = b;
        @(negedge clk);
        wr_cnt = write_to ? 1 : 0;
        @(posedge clk); #1;
        ctrl_DIV      = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
        lat = 0;
        forever begin
            lat++;
            @(negedge clk);
            if (data_resultRDY) break;
            if (write_to) wr_cnt++;
            if (lat > 40) break;
            @(posedge clk); #1;
        end
        exp = exp_q.pop_front();
        chk({tag, " latency"}, 64'(lat), 64'(exp_lat));
        chk({tag, " write_to cycles"}, 64'(wr_cnt), 64'(exp_lat));
        chk({tag, " write_to in rdy"}, 64'(write_to), 64'd0);
        chk({tag, " quotient"}, 64'(data_result), 64'(exp[31:0]));
        chk({tag, " remainder"}, 64'(data_remainder), 64'(exp[63:32]));
        chk({tag, " exception"}, 64'(data_exception), 64'(exp[64]));
        // One idle cycle later: strobe gone, results held.
        @(posedge clk); #1;
        @(negedge clk);
        chk({tag, " rdy one cycle"}, 64'(data_resultRDY), 64'd0);
        chk({tag, " quotient held"}, 64'(data_result), 64'(exp[31:0]));
        chk({tag, " remainder held"}, 64'(data_remainder), 64'(exp[63:32]));
        chk({tag, " exception held"}, 64'(data_exception), 64'(exp[64]));
        @(posedge clk); #1;
    endtask

    // Idle cycles while counting any result strobes seen.
    task automatic idle_cycles(input int n, output int rdy_seen);
        rdy_seen = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (data_resultRDY) rdy_seen++;
            @(posedge clk); #1;
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int          seen;
        logic [31:0] a;
        logic [31:0] b;

        ctrl_reset    = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = '0;
        data_operandB = '0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("reset rdy", 64'(data_resultRDY), 64'd0);
        chk("reset exception", 64'(data_exception), 64'd0);
        chk("reset write_to", 64'(write_to), 64'd0);
        chk("reset quotient", 64'(data_result), 64'd0);
        chk("reset remainder", 64'(data_remainder), 64'd0);
        @(posedge clk); #1;
        ctrl_reset = 1'b1;
        @(posedge clk); #1;

        // Idle: nothing written.
        @(negedge clk);
        chk("idle write_to", 64'(write_to), 64'd0);
        @(posedge clk); #1;

        // Directed cases.
        run_div(32'd100, 32'd7, "100/7");
        run_div(-32'sd100, 32'd7, "-100/7");
        run_div(32'd100, -32'sd7, "100/-7");
        run_div(32'd5, 32'd0, "5/0");
        run_div(32'h8000_0000, 32'hFFFF_FFFF, "min/-1");
        run_div(32'd3, 32'd9, "3/9");
        run_div(32'h8000_0000, 32'h8000_0000, "min/min");
        run_div(32'h7FFF_FFFF, 32'h8000_0000, "max/min");

        // Restart while running: only the second divide reports.
        start_only(32'd100, 32'd7);
        idle_cycles(9, seen);
        chk("restart no early rdy", 64'(seen), 64'd0);
        run_div(32'd81, 32'd9, "restart 81/9");

        // Restart while in DONE of a divide-by-zero.
        start_only(32'd7, 32'd0);
        run_div(32'd50, 32'd5, "restart from done");

        // Reset in the middle of a run.
        start_only(32'd100, 32'd7);
        idle_cycles(14, seen);
        ctrl_reset = 1'b0;
        @(negedge clk);
        if (data_resultRDY) seen++;
        @(posedge clk); #1;
        ctrl_reset = 1'b1;
        @(negedge clk);
        chk("midreset quotient", 64'(data_result), 64'd0);
        chk("midreset remainder", 64'(data_remainder), 64'd0);
        chk("midreset exception", 64'(data_exception), 64'd0);
        chk("midreset write_to", 64'(write_to), 64'd0);
        chk("midreset rdy", 64'(data_resultRDY), 64'd0);
        @(posedge clk); #1;
        begin
            int later;
            idle_cycles(40, later);
            chk("midreset no rdy", 64'(seen + later), 64'd0);
        end
        run_div(32'd1000, 32'd33, "after reset");

        // Random divides with a mix of magnitudes.
        for (int i = 0; i < 24; i++) begin
            a = $urandom;
            case ($urandom_range(0, 3))
                0:       b = $urandom_range(1, 15);
                1:       b = -$urandom_range(1, 300);
                2:       b = $urandom;
                default: b = $urandom >> $urandom_range(0, 31);
            endcase
            if ($urandom_range(0, 3) == 0) a = a >> $urandom_range(0, 31);
            run_div(a, b, $sformatf("rand%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
